serial_nibble_loader: RTL
=========================

# serial_nibble_loader

Serial-to-parallel loader that sits directly upstream of the 4-bit `Register` stage. It assembles a WIDTH-bit word from a bit-serial stream, MSB first, and optionally checks an even-parity bit. It then presents the word on `d` with a one-cycle `d_valid` strobe, so the downstream register can capture it on the next `clk` edge. Malformed frames are flagged and never disturb the last good word.

## Interface

- `WIDTH`, default 4: word width; matches the downstream register's `d`.
- `PARITY_EN`, default 1: 1 = a parity bit follows the data bits; 0 = no parity phase.

Ports:

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sin` in 1: serial data bit; sampled only when `sin_valid`=1.
- `sin_valid` in 1: qualifies `sin` for the current edge.
- `abort` in 1: discards any partially received frame.
- `d` out WIDTH: last correctly received word; feeds the register `d`.
- `d_valid` out 1: one-cycle pulse when `d` has just been updated.
- `par_err` out 1: one-cycle pulse on parity mismatch.
- `busy` out 1: high while a partial frame is held.

## Operation

- State machine: COLLECT, then PARITY (PARITY only when `PARITY_EN`=1).
- Internal state:
  - shift register `sh[WIDTH-1:0]`;
  - bit counter `cnt`, width `$clog2(WIDTH+1)`, range 0..WIDTH-1;
  - running parity `acc` (XOR of the accepted data bits).
- COLLECT, on an edge with `sin_valid`=1:
  - `sh <= {sh[WIDTH-2:0], sin}` and `acc <= acc ^ sin`.
  - If `cnt`==WIDTH-1, the word is complete:
    - with `PARITY_EN`=1, go to PARITY;
    - with `PARITY_EN`=0, load `d` with the completed word and pulse `d_valid`.
  - In both cases `cnt` then wraps to 0.
  - Otherwise `cnt <= cnt+1`.
- PARITY, on an edge with `sin_valid`=1, the received parity bit `p` is checked:
  - If `acc ^ p` == 0 (total count of ones even): `d <= sh`, pulse `d_valid`.
  - Otherwise: pulse `par_err` and leave `d` unchanged.
  - In both cases return to COLLECT with `cnt`=0 and `acc`=0.
- `sin_valid`=0: hold all state. Gaps of any length between bits are legal.
- `abort`=1: go to COLLECT with `cnt`=0 and `acc`=0. The `sin` bit in that cycle is ignored and `d` is unchanged.
- Priority: `rst` > `abort` > `sin_valid`.
- `busy` = (`cnt`!=0) or (state==PARITY). It is registered-state derived; there is no combinational path from the inputs.
- There is no back-pressure. The downstream stage must capture `d` whenever `d_valid` is high.

## Timing

- Reset values: `d`=0, `d_valid`=0, `par_err`=0, `busy`=0, state=COLLECT, `cnt`=0, `sh`=0, `acc`=0.
- Reset mid-frame discards the partial frame. It takes effect at the first edge with `rst`=1.
- Latency from the edge that accepts the final bit to outputs:
  - The final bit is the parity bit (`PARITY_EN`=1) or the last data bit (`PARITY_EN`=0).
  - `d` and `d_valid` (or `par_err`) are visible immediately after that same edge.
  - Each pulse lasts exactly one cycle.
- Throughput: one bit per cycle.
  - A frame occupies WIDTH+`PARITY_EN` consecutive accepted bits.
  - The first bit of the next frame may be accepted in the same cycle that `d_valid` or `par_err` is high.
- `d` remains stable between `d_valid` pulses, including across `par_err` and `abort`.
- `abort` asserted in the same cycle as a frame's final bit: the frame is discarded, with no pulse and no `d` update.

## Test plan

- Reset then good frame (WIDTH=4, `PARITY_EN`=1): send 1,0,1,1 then parity 1, one bit per cycle.
  - `d`=4'b1011 and `d_valid` high for exactly one cycle after the 5th edge.
  - `busy` high from edge 1 through edge 4.
- Bad parity: send 0,1,1,0 with parity 1.
  - `par_err` pulses for one cycle.
  - `d` stays 4'b1011 and `d_valid` stays 0.
- Gaps and back-to-back frames: send 1,1,1,1,p=0 with `sin_valid` low for 3 cycles between bits 2 and 3, then immediately send 0,0,0,1,p=1.
  - Two `d_valid` pulses, with `d`=4'b1111 then 4'b0001.
- Abort: send 1,0 then `abort`=1 with `sin_valid`=1 and `sin`=1 in the same cycle.
  - `busy` drops to 0.
  - Next send 0,1,0,0,p=1: `d`=4'b0100.
- Reset mid-frame: send 3 bits, then assert `rst` for 1 cycle.
  - All outputs return to their reset values.
  - A following frame 1,0,0,1,p=0 gives `d`=4'b1001.
- `PARITY_EN`=0 build: send 1,1,0,1.
  - `d`=4'b1101 and `d_valid` high after the 4th edge.
  - The next bit starts a new word.

Source files
------------

// File: rtl/serial_nibble_loader.sv
// Bit-serial to parallel loader, MSB first, with optional even-parity check.
// Presents each good word on d with a one-cycle d_valid strobe.
module serial_nibble_loader #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] d,
    output logic             d_valid,
    output logic             par_err,
    output logic             busy
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    typedef enum logic [0:0] {
        COLLECT,
        PARITY
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              dv_q, dv_d;
    logic              pe_q, pe_d;
    logic [WIDTH-1:0]  shifted;

    assign shifted = {sh_q[WIDTH-2:0], sin};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        d_d     = d_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        // abort wins over a valid bit in the same cycle, so a frame whose
        // final bit coincides with abort produces no pulse at all
        if (abort) begin
            state_d = COLLECT;
            cnt_d   = '0;
            acc_d   = 1'b0;
        end else if (sin_valid) begin
            unique case (state_q)
                COLLECT: begin
                    sh_d  = shifted;
                    acc_d = acc_q ^ sin;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (PARITY_EN) begin
                            state_d = PARITY;
                        end else begin
                            d_d  = shifted;
                            dv_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if ((acc_q ^ sin) == 1'b0) begin
                        d_d  = sh_q;
                        dv_d = 1'b1;
                    end else begin
                        pe_d = 1'b1;
                    end
                    state_d = COLLECT;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            sh_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            d_q     <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
        end
    end

    assign d       = d_q;
    assign d_valid = dv_q;
    assign par_err = pe_q;
    assign busy    = (cnt_q != '0) || (state_q == PARITY);

endmodule
